// File: rtl/ins_encode_pkg.sv
// Shared RV32I opcode values, encoder state encodings and the field-bundle
// payload used by the instruction encoder.
package ins_encode_pkg;

    localparam logic [6:0] r_type = 7'b0110011;
    localparam logic [6:0] i_type = 7'b0010011;
    localparam logic [6:0] load   = 7'b0000011;
    localparam logic [6:0] store  = 7'b0100011;
    localparam logic [6:0] b_type = 7'b1100011;
    localparam logic [6:0] jal    = 7'b1101111;
    localparam logic [6:0] jalr   = 7'b1100111;
    localparam logic [6:0] lui    = 7'b0110111;
    localparam logic [6:0] auipc  = 7'b0010111;

    localparam logic [31:0] zero_word = 32'h0000_0000;

    localparam int unsigned state_w = 2;

    localparam logic [1:0] enc_idle  = 2'd0;
    localparam logic [1:0] enc_run   = 2'd1;
    localparam logic [1:0] enc_drain = 2'd2;
    localparam logic [1:0] enc_done  = 2'd3;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func;
        logic        func1;
        logic [31:0] imm;
    } ins_fields_t;

    // slli / srli / srai carry a 5-bit shamt instead of a 12-bit immediate
    function automatic logic is_shift(input logic [6:0] op, input logic [2:0] func);
        return (op == i_type) && ((func == 3'b001) || (func == 3'b101));
    endfunction

endpackage

// File: rtl/ins_encode_imm_pack.sv
// Inverse immediate generator: scatters imm into its instruction-word bit
// positions for the given format and flags immediates the format cannot hold.
module ins_encode_imm_pack
    import ins_encode_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  func,
    input  logic        func1,
    input  logic [31:0] imm,
    output logic [31:0] imm_word,
    output logic        imm_err
);

    logic sext11_ok;
    logic sext12_ok;
    logic sext20_ok;

    always_comb begin
        sext11_ok = (imm[31:11] == {21{imm[11]}});
        sext12_ok = (imm[31:12] == {20{imm[12]}});
        sext20_ok = (imm[31:20] == {12{imm[20]}});
        imm_word  = zero_word;
        imm_err   = 1'b0;

        // imm_err also covers opcodes this encoder does not know
        case (op)
            r_type: begin
                imm_word = zero_word;
            end
            i_type: begin
                if (is_shift(op, func)) begin
                    imm_word = {1'b0, func1, 5'b00000, imm[4:0], 20'h00000};
                    imm_err  = !sext11_ok || (imm[11:5] != 7'b0000000);
                end else begin
                    imm_word = {imm[11:0], 20'h00000};
                    imm_err  = !sext11_ok;
                end
            end
            load, jalr: begin
                imm_word = {imm[11:0], 20'h00000};
                imm_err  = !sext11_ok;
            end
            store: begin
                imm_word = {imm[11:5], 13'h0000, imm[4:0], 7'b0000000};
                imm_err  = !sext11_ok;
            end
            b_type: begin
                imm_word = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'b0000000};
                imm_err  = !sext12_ok || imm[0];
            end
            jal: begin
                imm_word = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
                imm_err  = !sext20_ok || imm[0];
            end
            lui, auipc: begin
                imm_word = {imm[31:12], 12'h000};
                imm_err  = (imm[11:0] != 12'h000);
            end
            default: begin
                imm_word = zero_word;
                imm_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ins_encode.sv
// Packs RV32I field bundles into instruction words and streams them into
// instruction memory at consecutive word addresses through one output register.
module ins_encode
    import ins_encode_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        func,
    input  logic              func1,
    input  logic [31:0]       imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  wr_cnt
);

    ins_fields_t fld;
    logic [31:0] imm_word;
    logic        imm_err;
    logic [31:0] reg_word;
    logic [31:0] enc_word;
    logic        mem_hs;
    logic        unused_base_lsbs;

    logic [state_w-1:0] state_q,    state_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic               mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic [CNT_W-1:0]   wr_cnt_q,   wr_cnt_d;

    assign fld              = {op, rd, rs1, rs2, func, func1, imm};
    assign mem_hs           = mem_we_q && mem_ready;
    assign unused_base_lsbs = ^base_addr[1:0];

    ins_encode_imm_pack u_imm_pack (
        .op       (fld.op),
        .func     (fld.func),
        .func1    (fld.func1),
        .imm      (fld.imm),
        .imm_word (imm_word),
        .imm_err  (imm_err)
    );

    // Register-field placement per format; immediate bits are OR-ed in after.
    always_comb begin
        reg_word = zero_word;
        case (fld.op)
            r_type:             reg_word = {1'b0, fld.func1, 5'b00000, fld.rs2, fld.rs1,
                                            fld.func, fld.rd, fld.op};
            i_type, load, jalr: reg_word = {12'h000, fld.rs1, fld.func, fld.rd, fld.op};
            store, b_type:      reg_word = {7'b0000000, fld.rs2, fld.rs1, fld.func,
                                            5'b00000, fld.op};
            jal, lui, auipc:    reg_word = {20'h00000, fld.rd, fld.op};
            default:            reg_word = zero_word;
        endcase
        enc_word = reg_word | imm_word;
    end

    // Load sequencing, output register, error capture and write counting.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        wr_cnt_d   = wr_cnt_q;
        in_ready   = 1'b0;

        if (mem_hs) begin
            mem_we_d = 1'b0;
            if (wr_cnt_q != {CNT_W{1'b1}}) begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            enc_idle: begin
                if (start) begin
                    state_d    = enc_run;
                    addr_d     = {base_addr[ADDR_W-1:2], 2'b00};
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    wr_cnt_d   = '0;
                end
            end
            enc_run: begin
                in_ready = !mem_we_q || mem_ready;
                if (in_valid && in_ready) begin
                    // A rejected bundle is consumed but leaves the slot address unchanged
                    if (imm_err) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            err_addr_d = addr_q;
                        end
                    end else begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = addr_q;
                        mem_data_d = enc_word;
                        addr_d     = addr_q + ADDR_W'(4);
                    end
                    if (in_last) begin
                        state_d = enc_drain;
                    end
                end
            end
            enc_drain: begin
                if (!mem_we_q || mem_hs) begin
                    state_d = enc_done;
                    done_d  = 1'b1;
                end
            end
            enc_done: begin
                state_d = enc_idle;
            end
            default: begin
                state_d = enc_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= enc_idle;
            addr_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_ins_encode.sv
// Self-checking bench for ins_encode: directed ISA vectors plus randomized
// loads checked by decoding the written words against the sent fields.
module tb_ins_encode;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_ST   = 7'h23;
    localparam logic [6:0] OP_B    = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_AUI  = 7'h17;
    localparam logic [6:0] OP_BAD  = 7'h0B;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func;
        logic        func1;
        logic [31:0] imm;
    } fld_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func;
    logic        func1;
    logic [31:0] imm;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        done;
    logic        err;
    logic [31:0] err_addr;
    logic [15:0] wr_cnt;

    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 0;
    int unsigned cyc = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int unsigned log_cyc[$];

    ins_encode #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .func(func), .func1(func1), .imm(imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .done(done), .err(err), .err_addr(err_addr), .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: logs every completed write handshake
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (mem_we === 1'b1 && mem_ready === 1'b1) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_data);
                log_cyc.push_back(cyc);
            end
        end
    end

    function automatic fld_t mk(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] f3, input logic f1,
                                input logic [31:0] im);
        fld_t f;
        f.op = o; f.rd = d; f.rs1 = s1; f.rs2 = s2; f.func = f3; f.func1 = f1; f.imm = im;
        return f;
    endfunction

    function automatic bit is_sh(input fld_t f);
        return (f.op == OP_I) && (f.func == 3'd1 || f.func == 3'd5);
    endfunction

    // Legality from the numeric range each format can represent
    function automatic bit legal(input fld_t f);
        int s;
        s = $signed(f.imm);
        case (f.op)
            OP_R:                  return 1'b1;
            OP_I:                  return is_sh(f) ? (f.imm < 32'd32) : (s >= -2048 && s <= 2047);
            OP_LD, OP_JALR, OP_ST: return s >= -2048 && s <= 2047;
            OP_B:                  return s >= -4096 && s <= 4094 && f.imm[0] == 1'b0;
            OP_JAL:                return s >= -1048576 && s <= 1048574 && f.imm[0] == 1'b0;
            OP_LUI, OP_AUI:        return f.imm[11:0] == 12'h000;
            default:               return 1'b0;
        endcase
    endfunction

    // Decodes a written word and confirms it reproduces the sent fields
    function automatic bit word_ok(input fld_t f, input logic [31:0] w);
        bit ok;
        logic [31:0] di;
        ok = (w[6:0] == f.op);
        case (f.op)
            OP_R: ok = ok && w[11:7] == f.rd && w[19:15] == f.rs1 && w[24:20] == f.rs2 &&
                       w[14:12] == f.func && w[30] == f.func1 && w[31] == 1'b0 && w[29:25] == 5'd0;
            OP_I, OP_LD, OP_JALR: begin
                ok = ok && w[11:7] == f.rd && w[19:15] == f.rs1 && w[14:12] == f.func;
                if (is_sh(f)) begin
                    ok = ok && w[24:20] == f.imm[4:0] && w[30] == f.func1 &&
                         w[31] == 1'b0 && w[29:25] == 5'd0;
                end else begin
                    di = {{20{w[31]}}, w[31:20]};
                    ok = ok && di == f.imm;
                end
            end
            OP_ST: begin
                di = {{20{w[31]}}, w[31:25], w[11:7]};
                ok = ok && w[19:15] == f.rs1 && w[24:20] == f.rs2 && w[14:12] == f.func && di == f.imm;
            end
            OP_B: begin
                di = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                ok = ok && w[19:15] == f.rs1 && w[24:20] == f.rs2 && w[14:12] == f.func && di == f.imm;
            end
            OP_JAL: begin
                di = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                ok = ok && w[11:7] == f.rd && di == f.imm;
            end
            OP_LUI, OP_AUI: ok = ok && w[11:7] == f.rd && w[31:12] == f.imm[31:12];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic fld_t rand_fld();
        fld_t f;
        int lo, hi, st, j;
        f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
        f.func = 3'($urandom); f.func1 = 1'($urandom);
        case ($urandom_range(0, 9))
            0: f.op = OP_R;   1: f.op = OP_I;    2: f.op = OP_LD;  3: f.op = OP_ST;
            4: f.op = OP_B;   5: f.op = OP_JAL;  6: f.op = OP_JALR;
            7: f.op = OP_LUI; 8: f.op = OP_AUI;  default: f.op = OP_BAD;
        endcase
        lo = -2048; hi = 2047; st = 1;
        if (f.op == OP_B)   begin lo = -4096;    hi = 4094;    st = 2; end
        if (f.op == OP_JAL) begin lo = -1048576; hi = 1048574; st = 2; end
        if (is_sh(f))       begin lo = 0;        hi = 31;      st = 1; end
        case ($urandom_range(0, 7))
            0: f.imm = $urandom;
            1: begin
                j = int'($urandom_range(0, 3));
                f.imm = 32'((j == 0) ? hi : (j == 1) ? hi + st : (j == 2) ? lo : lo - st);
            end
            default: begin
                if (f.op == OP_LUI || f.op == OP_AUI) f.imm = $urandom & 32'hFFFF_F000;
                else f.imm = 32'(lo + st * int'($urandom_range(0, 32'((hi - lo) / st))));
                if ($urandom_range(0, 7) == 0) f.imm = f.imm ^ 32'd1;
            end
        endcase
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic do_start(input logic [31:0] b);
        tick();
        start = 1'b1; base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input fld_t f, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_last = last;
        op = f.op; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2; func = f.func; func1 = f.func1; imm = f.imm;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            tick(); @(negedge clk); n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_accept in_ready=%b required 1 within 200 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 500) begin
            tick(); @(negedge clk); n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done done=%b required 1 within 500 cycles", nm, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; func = '0; func1 = 1'b0; imm = '0; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_data, done, err, err_addr, wr_cnt, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs we=%b addr=%h data=%h done=%b err=%b eaddr=%h cnt=%0d rdy=%b required all 0",
                     mem_we, mem_addr, mem_data, done, err, err_addr, wr_cnt, in_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_log(); mem_ready = 1'b1;
        do_start(32'h0000_0100);
        send(mk(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF), 1'b1);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_data !== 32'hFFF0_0093) begin
            errors++;
            $display("FAIL single_write we=%b addr=%h data=%h required 1 00000100 fff00093",
                     mem_we, mem_addr, mem_data);
        end
        wait_done("single");
        checks++;
        if (wr_cnt !== 16'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt wr_cnt=%0d err=%b required 1 0", wr_cnt, err);
        end
        tick(); @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse done=%b required 0 one cycle later", done);
        end
    endtask

    task automatic test_back_to_back();
        fld_t        fs[5];
        logic [31:0] ew[5];
        clear_log(); mem_ready = 1'b1;
        fs[0] = mk(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);        ew[0] = 32'h0010_00EF;
        fs[1] = mk(OP_B,   5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);  ew[1] = 32'hFE20_8EE3;
        fs[2] = mk(OP_ST,  5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8);           ew[2] = 32'h0020_A423;
        fs[3] = mk(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);   ew[3] = 32'h1234_52B7;
        fs[4] = mk(OP_R,   5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);           ew[4] = 32'h4020_81B3;
        do_start(32'h0);
        for (int i = 0; i < 5; i++) send(fs[i], i == 4);
        wait_done("stream");
        checks++;
        if (log_addr.size() != 5 || wr_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stream_count writes=%0d wr_cnt=%0d required 5 5", log_addr.size(), wr_cnt);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_addr[i] !== 32'(4 * i) || log_data[i] !== ew[i] || log_cyc[i] != log_cyc[0] + i) begin
                    errors++;
                    $display("FAIL stream_word%0d addr=%h data=%h cyc=+%0d required %h %h +%0d",
                             i, log_addr[i], log_data[i], log_cyc[i] - log_cyc[0], 32'(4 * i), ew[i], i);
                end
            end
        end
    endtask

    task automatic test_stall();
        fld_t a, b;
        a = mk(OP_I, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 32'd5);
        b = mk(OP_I, 5'd3, 5'd2, 5'd0, 3'd1, 1'b0, 32'd4);
        clear_log(); mem_ready = 1'b1;
        do_start(32'h0000_0200);
        send(a, 1'b0);
        mem_ready = 1'b0;
        in_valid = 1'b1; in_last = 1'b1;
        op = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; func = b.func; func1 = b.func1; imm = b.imm;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_data !== 32'h0050_8113 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d we=%b addr=%h data=%h rdy=%b required 1 00000200 00508113 0",
                         k, mem_we, mem_addr, mem_data, in_ready);
            end
            tick();
        end
        mem_ready = 1'b1;
        send(b, 1'b1);
        wait_done("stall");
        checks++;
        if (log_addr.size() != 2 || wr_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_count writes=%0d wr_cnt=%0d required 2 2", log_addr.size(), wr_cnt);
        end else begin
            checks++;
            if (log_addr[1] !== 32'h204 || log_data[1] !== 32'h0041_1193 || log_cyc[1] != log_cyc[0] + 1) begin
                errors++;
                $display("FAIL stall_reload addr=%h data=%h gap=%0d required 00000204 00411193 1",
                         log_addr[1], log_data[1], log_cyc[1] - log_cyc[0]);
            end
        end
    endtask

    task automatic test_reject();
        clear_log(); mem_ready = 1'b1;
        do_start(32'h0000_0300);
        send(mk(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0800), 1'b0);
        send(mk(OP_I, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0), 1'b0);
        send(mk(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3), 1'b1);
        wait_done("reject");
        checks++;
        if (err !== 1'b1 || err_addr !== 32'h300 || wr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reject_err err=%b err_addr=%h wr_cnt=%0d required 1 00000300 1", err, err_addr, wr_cnt);
        end
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 32'h300 || log_data[0] !== 32'h0000_0013) begin
            errors++;
            $display("FAIL reject_writes n=%0d first_addr=%h first_data=%h required 1 00000300 00000013",
                     log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'h0,
                     (log_data.size() > 0) ? log_data[0] : 32'h0);
        end
    endtask

    task automatic test_wrap();
        clear_log(); mem_ready = 1'b1;
        do_start(32'hFFFF_FFFF);
        checks++;
        if (err !== 1'b0 || err_addr !== 32'h0 || wr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL start_clear err=%b err_addr=%h wr_cnt=%0d required 0 0 0", err, err_addr, wr_cnt);
        end
        send(mk(OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h8000_0000), 1'b0);
        send(mk(OP_I, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd1), 1'b1);
        wait_done("wrap");
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 32'hFFFF_FFFC || log_addr[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr n=%0d a0=%h a1=%h required 2 fffffffc 00000000", log_addr.size(),
                     (log_addr.size() > 0) ? log_addr[0] : 32'h0, (log_addr.size() > 1) ? log_addr[1] : 32'h0);
        end
    endtask

    task automatic test_random();
        fld_t        f;
        fld_t        exp_f[$];
        logic [31:0] exp_a[$];
        logic [31:0] b, addr, e_addr;
        bit          e_err;
        int          n;
        for (int l = 0; l < 6; l++) begin
            exp_f.delete(); exp_a.delete();
            e_err = 1'b0; e_addr = '0;
            b = $urandom;
            addr = {b[31:2], 2'b00};
            clear_log(); rand_ready = 1'b1;
            do_start(b);
            n = int'($urandom_range(10, 30));
            for (int i = 0; i < n; i++) begin
                f = rand_fld();
                if (legal(f)) begin
                    exp_f.push_back(f); exp_a.push_back(addr); addr = addr + 32'd4;
                end else if (!e_err) begin
                    e_err = 1'b1; e_addr = addr;
                end
                if ($urandom_range(0, 3) == 0) tick();
                send(f, i == n - 1);
            end
            wait_done("random");
            checks++;
            if (err !== e_err || err_addr !== e_addr || wr_cnt !== 16'(exp_a.size())) begin
                errors++;
                $display("FAIL random%0d_status err=%b err_addr=%h wr_cnt=%0d required %b %h %0d",
                         l, err, err_addr, wr_cnt, e_err, e_addr, exp_a.size());
            end
            checks++;
            if (log_addr.size() != exp_a.size()) begin
                errors++;
                $display("FAIL random%0d_count writes=%0d required %0d", l, log_addr.size(), exp_a.size());
            end else begin
                for (int i = 0; i < exp_a.size(); i++) begin
                    checks++;
                    if (log_addr[i] !== exp_a[i] || !word_ok(exp_f[i], log_data[i])) begin
                        errors++;
                        $display("FAIL random%0d_word%0d addr=%h data=%h required addr %h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f1=%0d imm=%h",
                                 l, i, log_addr[i], log_data[i], exp_a[i], exp_f[i].op, exp_f[i].rd,
                                 exp_f[i].rs1, exp_f[i].rs2, exp_f[i].func, exp_f[i].func1, exp_f[i].imm);
                    end
                end
            end
        end
        rand_ready = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_rst_mid();
        clear_log(); mem_ready = 1'b0;
        do_start(32'h0000_0400);
        send(mk(OP_I, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7), 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_data, done, err, err_addr, wr_cnt, in_ready} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs we=%b addr=%h data=%h done=%b err=%b eaddr=%h cnt=%0d rdy=%b required all 0",
                     mem_we, mem_addr, mem_data, done, err, err_addr, wr_cnt, in_ready);
        end
        tick();
        rst = 1'b0;
        clear_log(); mem_ready = 1'b1;
        do_start(32'h0000_0500);
        send(mk(OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000), 1'b1);
        wait_done("rst_mid");
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 32'h500 || log_data[0] !== 32'hABCD_E3B7 || wr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_reload n=%0d addr=%h data=%h wr_cnt=%0d required 1 00000500 abcde3b7 1",
                     log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'h0,
                     (log_data.size() > 0) ? log_data[0] : 32'h0, wr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reject();
        test_wrap();
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
